// File: rtl/csr_timer_bank.sv
// Bank of NUM_TIMERS countdown timers (TCFG/TVAL/TICLR) beside the CSR file.
// Optional free-running 64-bit stable counter enabled by CSR_TIMER_STABLE_CNT_EN.
module csr_timer_bank #(
  parameter int unsigned NUM_TIMERS = 2,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [13:0] CSR_BASE   = 14'h041
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  output logic [31:0]           csr_rvalue,
  output logic                  csr_hit,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  timer_int_any,
  output logic [63:0]           stable_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ALL_ONES = '1;

  logic [31:0]           rd_data [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] rd_hit;
  logic [NUM_TIMERS-1:0] pend_next;
  logic                  any_q;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    localparam logic [13:0] ADDR_TCFG  = CSR_BASE + 14'(4 * i);
    localparam logic [13:0] ADDR_TVAL  = ADDR_TCFG + 14'd1;
    localparam logic [13:0] ADDR_TICLR = ADDR_TCFG + 14'd3;

    logic [CNT_WIDTH-1:0] tcfg_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 pend_q;
    logic [CNT_WIDTH-1:0] tcfg_next;
    logic                 sel_tcfg;
    logic                 sel_tval;
    logic                 sel_ticlr;
    logic                 wr_tcfg;
    logic                 clr;
    logic                 expired;
    logic                 running;

    assign sel_tcfg  = (csr_num == ADDR_TCFG);
    assign sel_tval  = (csr_num == ADDR_TVAL);
    assign sel_ticlr = (csr_num == ADDR_TICLR);

    // Per-bit merge; bits above CNT_WIDTH-1 are never stored.
    assign tcfg_next = (csr_wmask[CNT_WIDTH-1:0] & csr_wvalue[CNT_WIDTH-1:0])
                     | (~csr_wmask[CNT_WIDTH-1:0] & tcfg_q);
    assign wr_tcfg   = csr_we && sel_tcfg;
    assign clr       = csr_we && sel_ticlr && csr_wmask[0] && csr_wvalue[0];
    assign expired   = tcfg_q[0] && (cnt_q == '0);
    assign running   = tcfg_q[0] && (cnt_q != CNT_ALL_ONES);

    // Set wins over a coincident clear.
    assign pend_next[i] = expired || (pend_q && !clr);

    always_ff @(posedge clk) begin
      if (!resetn) begin
        tcfg_q <= '0;
        cnt_q  <= '1;
        pend_q <= 1'b0;
      end else begin
        pend_q <= pend_next[i];
        if (wr_tcfg) begin
          tcfg_q <= tcfg_next;
          if (tcfg_next[0]) begin
            cnt_q <= {tcfg_next[CNT_WIDTH-1:2], 2'b00};
          end
        end else if (running) begin
          if ((cnt_q == '0) && tcfg_q[1]) begin
            cnt_q <= {tcfg_q[CNT_WIDTH-1:2], 2'b00};
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
      end
    end

    assign rd_data[i] = sel_tcfg ? 32'(tcfg_q) :
                        sel_tval ? 32'(cnt_q)  : 32'h0;
    assign rd_hit[i]  = sel_tcfg || sel_tval || sel_ticlr;
    assign timer_int[i] = pend_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |pend_next;
    end
  end

  assign timer_int_any = any_q;

  // Address decode is one-hot across timers, so OR-combining is a mux.
  always_comb begin
    csr_rvalue = 32'h0;
    csr_hit    = 1'b0;
    for (int unsigned k = 0; k < NUM_TIMERS; k++) begin
      csr_rvalue = csr_rvalue | rd_data[k];
      csr_hit    = csr_hit | (csr_re && rd_hit[k]);
    end
  end

`ifdef CSR_TIMER_STABLE_CNT_EN
  logic [63:0] stable_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_q + 64'd1;
    end
  end

  assign stable_cnt = stable_q;
`else
  assign stable_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_csr_timer_bank.sv
// Bench for csr_timer_bank: default instance plus an 8-bit single-timer instance at 0x100.
module tb_csr_timer_bank;

  logic        clk = 1'b0;
  logic        resetn;
  logic        csr_re;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] rv, rv8;
  logic        hit, hit8;
  logic [1:0]  ti;
  logic [0:0]  ti8;
  logic        any, any8;
  logic [63:0] sc, sc8;

`ifdef CSR_TIMER_STABLE_CNT_EN
  localparam bit STABLE = 1'b1;
`else
  localparam bit STABLE = 1'b0;
`endif

  always #5 clk = ~clk;

  csr_timer_bank u_dut (
    .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_rvalue(rv), .csr_hit(hit), .timer_int(ti), .timer_int_any(any),
    .stable_cnt(sc)
  );

  csr_timer_bank #(.NUM_TIMERS(1), .CNT_WIDTH(8), .CSR_BASE(14'h100)) u_w8 (
    .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_rvalue(rv8), .csr_hit(hit8), .timer_int(ti8), .timer_int_any(any8),
    .stable_cnt(sc8)
  );

  typedef enum int {S_RV, S_HIT, S_TI, S_ANY, S_SC, S_RV8, S_HIT8} sel_e;
  typedef struct { sel_e sel; logic [63:0] exp; string name; } exp_t;
  typedef struct { logic re; logic [13:0] num; logic [31:0] rv; logic hit; } vec_t;

  exp_t sb[$];
  vec_t vecs [11];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [63:0] actual(sel_e s);
    case (s)
      S_RV:    return 64'(rv);
      S_HIT:   return 64'(hit);
      S_TI:    return 64'(ti);
      S_ANY:   return 64'(any);
      S_SC:    return sc;
      S_RV8:   return 64'(rv8);
      S_HIT8:  return 64'(hit8);
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] exp_sc(int unsigned n);
    return STABLE ? 64'(n) : 64'h0;
  endfunction

  task automatic exp_push(sel_e s, logic [63:0] v, string n);
    exp_t e;
    e.sel  = s;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: actual=%0h required=%0h", e.name, a, e.exp);
      end
    end
  endtask

  // Compare on the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(logic re, logic [13:0] num, logic we, logic [31:0] mask, logic [31:0] wval);
    csr_re     = re;
    csr_num    = num;
    csr_we     = we;
    csr_wmask  = mask;
    csr_wvalue = wval;
  endtask

  task automatic rd(logic [13:0] num);
    bus(1'b1, num, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(logic [13:0] num, logic [31:0] mask, logic [31:0] wval);
    bus(1'b1, num, 1'b1, mask, wval);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 14'h041, 32'h0000_0000, 1'b1};
    vecs[1]  = '{1'b1, 14'h042, 32'hFFFF_FFFF, 1'b1};
    vecs[2]  = '{1'b1, 14'h043, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 14'h044, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 14'h045, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 14'h046, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{1'b1, 14'h047, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 14'h048, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 14'h049, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 14'h040, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 14'h042, 32'hFFFF_FFFF, 1'b0};

    resetn = 1'b0;
    bus(1'b0, 14'h0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Post-reset address decode
    for (int i = 0; i < 11; i++) begin
      bus(vecs[i].re, vecs[i].num, 1'b0, 32'h0, 32'h0);
      exp_push(S_RV, 64'(vecs[i].rv), $sformatf("decode_rv_%0h", vecs[i].num));
      exp_push(S_HIT, 64'(vecs[i].hit), $sformatf("decode_hit_%0h", vecs[i].num));
      exp_push(S_TI, 64'h0, "reset_ti");
      exp_push(S_ANY, 64'h0, "reset_any");
      tick();
    end

    // One-shot countdown from 20
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0015);
    exp_push(S_RV, 64'h0, "tcfg0_old_during_write");
    tick();
    for (int k = 20; k >= 0; k--) begin
      rd(14'h042);
      exp_push(S_RV, 64'(k), "oneshot_tval");
      exp_push(S_TI, 64'h0, "oneshot_ti_low");
      tick();
    end
    rd(14'h042);
    exp_push(S_RV, 64'hFFFF_FFFF, "oneshot_wrap");
    exp_push(S_TI, 64'h1, "oneshot_pending");
    exp_push(S_ANY, 64'h1, "oneshot_any");
    tick();
    rd(14'h042);
    exp_push(S_RV, 64'hFFFF_FFFF, "oneshot_halt");
    tick();
    wr(14'h044, 32'h1, 32'h1);
    exp_push(S_RV, 64'h0, "ticlr_reads_zero");
    exp_push(S_HIT, 64'h1, "ticlr_hit");
    exp_push(S_TI, 64'h1, "ticlr_before_edge");
    tick();
    rd(14'h042);
    exp_push(S_TI, 64'h0, "ticlr_cleared");
    exp_push(S_ANY, 64'h0, "ticlr_any_cleared");
    tick();

    // Periodic reload of 8, period 9
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
    tick();
    for (int k = 0; k <= 8; k++) begin
      rd(14'h042);
      exp_push(S_RV, 64'(8 - k), "periodic_tval");
      exp_push(S_TI, 64'h0, "periodic_ti_low");
      tick();
    end
    wr(14'h044, 32'h1, 32'h1);
    exp_push(S_TI, 64'h1, "periodic_set");
    tick();
    for (int k = 7; k >= 1; k--) begin
      rd(14'h042);
      exp_push(S_RV, 64'(k), "periodic_tval2");
      exp_push(S_TI, 64'h0, "periodic_cleared");
      tick();
    end
    wr(14'h044, 32'h1, 32'h1);
    exp_push(S_TI, 64'h0, "coincide_before");
    tick();
    rd(14'h042);
    exp_push(S_TI, 64'h1, "set_beats_clear");
    exp_push(S_RV, 64'h8, "periodic_reload");
    tick();
    wr(14'h041, 32'hFFFF_FFFF, 32'h0);
    tick();
    wr(14'h044, 32'h1, 32'h1);
    tick();
    rd(14'h042);
    exp_push(S_RV, 64'h7, "stopped_hold");
    exp_push(S_TI, 64'h0, "stopped_cleared");
    tick();

    // Masked write to timer 1 only
    wr(14'h045, 32'h1, 32'h9);
    tick();
    rd(14'h046);
    exp_push(S_RV, 64'h0, "t1_loaded_zero");
    exp_push(S_TI, 64'h0, "t1_not_yet");
    tick();
    rd(14'h046);
    exp_push(S_RV, 64'hFFFF_FFFF, "t1_wrapped");
    exp_push(S_TI, 64'h2, "t1_pending");
    exp_push(S_ANY, 64'h1, "t1_any");
    tick();
    rd(14'h045);
    exp_push(S_RV, 64'h1, "t1_tcfg_masked");
    tick();
    rd(14'h041);
    exp_push(S_RV, 64'h0, "t0_tcfg_untouched");
    tick();
    rd(14'h042);
    exp_push(S_RV, 64'h7, "t0_cnt_untouched");
    exp_push(S_TI, 64'h2, "t0_pending_untouched");
    tick();

    // 8-bit instance
    wr(14'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_push(S_RV, 64'h0, "main_miss_0x100");
    exp_push(S_HIT, 64'h0, "main_nohit_0x100");
    tick();
    rd(14'h101);
    exp_push(S_RV8, 64'hFC, "w8_tval_start");
    exp_push(S_HIT8, 64'h1, "w8_tval_hit");
    tick();
    rd(14'h100);
    exp_push(S_RV8, 64'hFF, "w8_tcfg_trunc");
    tick();
    rd(14'h102);
    exp_push(S_RV8, 64'h0, "w8_reserved_rv");
    exp_push(S_HIT8, 64'h0, "w8_reserved_hit");
    tick();
    rd(14'h043);
    exp_push(S_RV, 64'h0, "reserved_0x43_rv");
    exp_push(S_HIT, 64'h0, "reserved_0x43_hit");
    tick();

    // Reset in the middle of a countdown from 100
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0065);
    tick();
    for (int k = 0; k <= 50; k++) begin
      rd(14'h042);
      exp_push(S_RV, 64'(100 - k), "count100_tval");
      exp_push(S_TI, 64'h2, "count100_ti");
      if (k == 50) resetn = 1'b0;
      tick();
    end
    resetn = 1'b1;
    rd(14'h042);
    exp_push(S_RV, 64'hFFFF_FFFF, "midreset_tval");
    exp_push(S_TI, 64'h0, "midreset_ti");
    exp_push(S_ANY, 64'h0, "midreset_any");
    exp_push(S_SC, exp_sc(0), "midreset_stable");
    tick();
    rd(14'h041);
    exp_push(S_RV, 64'h0, "midreset_tcfg");
    exp_push(S_SC, exp_sc(1), "stable_cnt_1");
    tick();
    for (int k = 2; k <= 10; k++) begin
      rd(14'h042);
      exp_push(S_SC, exp_sc(k), "stable_cnt_run");
      tick();
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_timer_bank.md
Name: csr_timer_bank

Overview:
- Parametrised successor of the CSR-file timer logic. Provides NUM_TIMERS independent countdown timers (TCFG/TVAL/TICLR per timer) with configurable counter width and CSR base address.
- Exposes a level-sensitive pending vector that the CSR file ORs into ESTAT.IS.
- Sits beside the CSR file and shares its csr_num/csr_we/csr_wmask/csr_wvalue write bus and its combinational read mux.

Parameters:
- NUM_TIMERS, 2: number of independent timers. Legal range 1..4.
- CNT_WIDTH, 32: counter width in bits. Legal range 8..32. The TCFG InitVal field is bits [CNT_WIDTH-1:2].
- CSR_BASE, 14'h041: CSR number of timer 0's TCFG.

Ports:
- clk  in  1  core clock.
- resetn  in  1  synchronous, active-low reset.
- csr_re  in  1  read enable (qualifies csr_hit only).
- csr_num  in  14  CSR number, shared by read and write.
- csr_we  in  1  write strobe.
- csr_wmask  in  32  per-bit write mask.
- csr_wvalue  in  32  write data.
- csr_rvalue  out  32  combinational read data; 0 when the address misses.
- csr_hit  out  1  csr_re and csr_num decodes to a register of this block.
- timer_int  out  NUM_TIMERS  per-timer pending bit (ESTAT.TI equivalent).
- timer_int_any  out  1  OR of timer_int.
- stable_cnt  out  64  free-running counter (see Optional Feature).

Behaviour:
- Address map, timer i:
  - CSR_BASE+4i+0 = TCFG (RW).
  - +1 = TVAL (RO).
  - +3 = TICLR (W1C of bit 0; reads return 0).
  - +2 is reserved: reads 0, writes ignored, csr_hit=0.
  - With the defaults, timer 0 sits at 0x41/0x42/0x44.
- TCFG layout:
  - bit0 En; bit1 Periodic; [CNT_WIDTH-1:2] InitVal.
  - Bits above CNT_WIDTH-1 read 0 and are not stored.
  - Writes are merged per bit: new = mask&wvalue | ~mask&old.
- Reset (resetn=0 at posedge), every timer: En=0, Periodic=0, InitVal=0, cnt = all-ones, pending=0. Outputs are therefore timer_int=0, timer_int_any=0, csr_rvalue driven purely by address decode, stable_cnt=0. A reset in the middle of a countdown aborts it the next edge.
- Counter update, per timer, priority high to low:
  1. TCFG write whose merged next value has En=1: cnt <= {InitVal_next, 2'b00}.
  2. En=1 and cnt != all-ones, with cnt==0 and Periodic=1: cnt <= {InitVal, 2'b00}.
  3. En=1 and cnt != all-ones, otherwise: cnt <= cnt-1. A one-shot wraps from 0 to all-ones and then halts.
  4. Otherwise: hold.
- A TCFG write with En_next=0 stops the count and holds cnt.
- Pending:
  - Set at the edge following any cycle where En=1 and cnt==0.
  - Cleared by a TICLR write with mask[0]&wvalue[0].
  - If set and clear coincide, set wins.
  - Pending is independent of En after it is set.
- TVAL read returns cnt zero-extended to 32 bits, from the same cycle (no latency).
- Reads are combinational; writes take effect at the next posedge.
- A write to TCFG of timer i never affects timer j.
- InitVal=0 with En=1: cnt loads 0, pending sets the next cycle. If Periodic=1, it reloads 0 every cycle, so pending cannot be cleared while that configuration is held.

Optional Feature:
- Macro CSR_TIMER_STABLE_CNT_EN.
- Defined: stable_cnt is a 64-bit counter that resets to 0 and increments by 1 every cycle. It wraps 2^64-1 -> 0. It is not CSR-writable.
- Undefined: no counter register exists; stable_cnt is tied to 64'h0.

Test Plan:
- Reset check: hold resetn=0 for 3 cycles, then read TVAL at 0x42 -> 32'hFFFFFFFF; timer_int=0; csr_hit=1.
- One-shot: write 0x41 = 32'h0000_0015 (InitVal=5 so cnt=20, En=1) -> TVAL reads 20,19,…,0 on successive cycles. timer_int[0] rises the cycle after 0, TVAL then reads FFFFFFFF and holds. Write 0x44=1 -> timer_int[0]=0.
- Periodic: write 0x41 = 32'h0000_000B (cnt=8, periodic) -> timer_int[0] sets every 9 cycles. TICLR written in the same cycle as a set leaves pending=1.
- Independence and mask: write 0x45 = 32'h0000_0009 with wmask=32'h1 -> timer 1 En=1, InitVal stays 0, cnt loads 0, timer_int[1] sets next cycle. Timer 0 is unaffected.
- Width: CNT_WIDTH=8, write TCFG = 32'hFFFF_FFFF -> TCFG reads 32'h0000_00FF, TVAL starts at 32'h0000_00FC. Reads of 0x43 return 0 with csr_hit=0.
- Mid-count reset: start a countdown of 100 and pulse resetn=0 at cnt=50 -> next cycle TVAL=FFFFFFFF, TCFG=0, pending=0. With CSR_TIMER_STABLE_CNT_EN, stable_cnt=0 after reset and reads 10 ten cycles later.
